inst_encode: RTL
================

# inst_encode

Instruction encoder for the 5-stage RV32I core's test/boot path: the inverse of the ID-stage decoder. It accepts split instruction fields (opcode, register indices, funct3/funct7[5], full 32-bit immediate), packs them into a 32-bit RV32I word, tags each word with a word-aligned instruction-memory address, and buffers results in a small FIFO feeding the instruction-memory loader.

## Interface
- ADDR_W, 12, width of generated byte address; wraps modulo 2^ADDR_W
- DEPTH, 4, output FIFO depth; power of two, at least 2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- base_load  in  1  load address counter from base_addr
- base_addr  in  ADDR_W  new counter value; bits [1:0] ignored and forced to 0
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept; equals !full
- in_opcode  in  7  opcode
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_msg  in  4  {funct7[5], funct3}
- in_imm  in  32  sign-extended immediate in decoder form (U: low 12 bits zero)
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer pop
- out_data  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_data
- err_valid  out  1  one-cycle pulse, input rejected
- err_code  out  2  01 unknown opcode, 10 imm out of range, 11 imm misaligned; held until next error
- err_cnt  out  8  saturating count of rejected inputs

## Operation
- Accept when in_valid && in_ready. Encoding is combinational from the fields; the result and current address are written into the FIFO the same cycle.
- Formats by opcode: 0110111/0010111 U (inst[31:12]=imm[31:12]); 1101111 J; 1100111, 0000011, 0001111, 1110011 I; 0010011 I, except funct3 001/101 use shift form inst[31:25]={0,msg[3],00000}, inst[24:20]=imm[4:0]; 1100011 B; 0100011 S; 0110011 R with funct7={0,msg[3],00000}.
- Unused fields of a format are not emitted (e.g. in_rs2 ignored for I-type, rd ignored for S/B).
- Any other opcode: not enqueued, err_valid pulse, err_code=01, err_cnt+1. Always active.
- Address counter: accepted word gets current counter; counter += 4 after each accept, wrapping at 2^ADDR_W. Rejected inputs do not advance it.
- base_load takes priority: if it coincides with an accept, the word gets base_addr and the counter becomes base_addr+4.
- Pop when out_valid && out_ready; push and pop in the same cycle are both honoured when not full.
- err_cnt saturates at 255.

## Timing
- Reset (async): FIFO empty, counter 0, out_valid 0, out_data 0, out_addr 0, err_valid 0, err_code 00, err_cnt 0. in_ready is 1 from the first clock after rst deasserts.
- Latency: a word accepted at edge N is visible on out_data/out_addr after edge N if the FIFO was empty (registered FIFO head, no combinational pass-through).
- in_ready = !full, regardless of out_ready; a full FIFO with a simultaneous pop does not accept that cycle.
- err_valid is registered and asserts the cycle after the rejected handshake.
- rst mid-stream discards FIFO contents and resets the counter. It does not wait for the pending handshake.

## Configuration
- INST_ENC_RANGE_CHECK_EN defined: reject (code 10) I/S imm outside [-2048,2047], shift imm outside [0,31], B outside [-4096,4094], J outside [-2^20,2^20-2], U with imm[11:0]!=0; reject (code 11) odd B/J imm. Range (10) wins over misalignment (11).
- Undefined: no range or alignment checks; fields are truncated to format width, and imm[0] is dropped for B/J. Code 01 is still reported.

## Test plan
- addi x1,x0,5 (0010011, rd=1, rs1=0, msg=0000, imm=5) after reset -> out_data 0x00500093, out_addr 0x000 one cycle later.
- lui x2,0x12345 (imm 0x12345000), then sub x3,x1,x2 (msg=1000) -> 0x12345137 @0x004, 0x402081B3 @0x008.
- beq x1,x2,+8 (1100011, imm 8) -> 0x00208463. With the macro defined, imm=3 -> err_code 11, nothing enqueued, counter unchanged.
- Hold out_ready=0 and push 5 words with DEPTH=4 -> in_ready drops after 4 words. Raise out_ready -> words drain in order with addresses 0x0/0x4/0x8/0xC, then the 5th word is accepted.
- base_load with base_addr=0xFFC concurrent with an accept, then one more accept -> addresses 0xFFC then 0x000 (wrap).
- Opcode 1111111 -> err_code 01, err_cnt increments. Assert rst with 2 words queued -> out_valid 0 and err_cnt 0 immediately.

Source files
------------

// File: rtl/inst_encode.sv
// RV32I instruction encoder: packs split decoder fields into 32-bit words, tags them with a
// word-aligned byte address and queues them for the loader. Optional INST_ENC_RANGE_CHECK_EN adds imm checks.
module inst_encode #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [3:0]        in_msg,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [7:0]        err_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_U, FMT_J, FMT_I, FMT_SH, FMT_B, FMT_S, FMT_R, FMT_BAD
    } fmt_e;

    fmt_e              fmt_s;
    logic [31:0]       word_s;
    logic [2:0]        f3_s;
    logic [6:0]        f7_s;
    logic              range_bad_s;
    logic              misalign_s;
    logic [1:0]        err_code_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] addr_base_s;
    logic [ADDR_W-1:0] addr_use_s;

    logic [31:0]       data_q [DEPTH];
    logic [ADDR_W-1:0] tag_q  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_ready_q, out_valid_q;
    logic              err_valid_q;
    logic [1:0]        err_code_q;
    logic [7:0]        err_cnt_q;

    assign f3_s = in_msg[2:0];
    assign f7_s = {1'b0, in_msg[3], 5'b00000};

    // Opcode to instruction format; shift-immediate ops get their own format.
    always_comb begin
        fmt_s = FMT_BAD;
        case (in_opcode)
            OP_LUI, OP_AUIPC:                    fmt_s = FMT_U;
            OP_JAL:                              fmt_s = FMT_J;
            OP_JALR, OP_LOAD, OP_FENCE, OP_SYSTEM: fmt_s = FMT_I;
            OP_IMM: begin
                if ((f3_s == 3'b001) || (f3_s == 3'b101)) begin
                    fmt_s = FMT_SH;
                end else begin
                    fmt_s = FMT_I;
                end
            end
            OP_BRANCH:                           fmt_s = FMT_B;
            OP_STORE:                            fmt_s = FMT_S;
            OP_REG:                              fmt_s = FMT_R;
            default:                             fmt_s = FMT_BAD;
        endcase
    end

    // Field packing; fields a format does not carry are simply not emitted.
    always_comb begin
        word_s = 32'h0000_0000;
        case (fmt_s)
            FMT_U:  word_s = {in_imm[31:12], in_rd, in_opcode};
            FMT_J:  word_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            FMT_I:  word_s = {in_imm[11:0], in_rs1, f3_s, in_rd, in_opcode};
            FMT_SH: word_s = {f7_s, in_imm[4:0], in_rs1, f3_s, in_rd, in_opcode};
            FMT_B:  word_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3_s,
                              in_imm[4:1], in_imm[11], in_opcode};
            FMT_S:  word_s = {in_imm[11:5], in_rs2, in_rs1, f3_s, in_imm[4:0], in_opcode};
            FMT_R:  word_s = {f7_s, in_rs2, in_rs1, f3_s, in_rd, in_opcode};
            default: word_s = 32'h0000_0000;
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    // True when v is representable as a signed (msb+1)-bit value.
    function automatic logic sext_ok(input logic [31:0] v, input int msb);
        logic [31:0] sh;
        sh = $signed(v) >>> msb;
        return (sh == 32'h0000_0000) || (sh == 32'hFFFF_FFFF);
    endfunction

    // Immediate range and alignment checks; B/J top values are odd-only so they fail range first.
    always_comb begin
        range_bad_s = 1'b0;
        misalign_s  = 1'b0;
        case (fmt_s)
            FMT_U:       range_bad_s = |in_imm[11:0];
            FMT_I, FMT_S: range_bad_s = !sext_ok(in_imm, 11);
            FMT_SH:      range_bad_s = |in_imm[31:5];
            FMT_B: begin
                range_bad_s = !sext_ok(in_imm, 12) || (in_imm == 32'h0000_0FFF);
                misalign_s  = in_imm[0];
            end
            FMT_J: begin
                range_bad_s = !sext_ok(in_imm, 20) || (in_imm == 32'h000F_FFFF);
                misalign_s  = in_imm[0];
            end
            default: begin
                range_bad_s = 1'b0;
                misalign_s  = 1'b0;
            end
        endcase
    end
`else
    assign range_bad_s = 1'b0;
    assign misalign_s  = 1'b0;
`endif

    // Error classification: unknown opcode first, then range, then alignment.
    always_comb begin
        err_code_s = 2'b00;
        if (fmt_s == FMT_BAD) begin
            err_code_s = 2'b01;
        end else if (range_bad_s) begin
            err_code_s = 2'b10;
        end else if (misalign_s) begin
            err_code_s = 2'b11;
        end else begin
            err_code_s = 2'b00;
        end
    end

    assign accept_s    = in_valid && in_ready_q;
    assign push_s      = accept_s && (err_code_s == 2'b00);
    assign pop_s       = out_ready && out_valid_q;
    assign addr_base_s = base_addr & ~ADDR_W'(2'd3);
    assign addr_use_s  = base_load ? addr_base_s : addr_q;

    // Next-state for FIFO occupancy and the address counter.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
        if (push_s) begin
            addr_d = addr_use_s + ADDR_W'(3'd4);
        end else if (base_load) begin
            addr_d = addr_base_s;
        end else begin
            addr_d = addr_q;
        end
    end

    // FIFO storage, pointers, handshake flags and error reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 32'h0000_0000;
                tag_q[i]  <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_cnt_q   <= 8'd0;
        end else begin
            if (push_s) begin
                data_q[wr_ptr_q] <= word_s;
                tag_q[wr_ptr_q]  <= addr_use_s;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
            end
            count_q     <= count_d;
            addr_q      <= addr_d;
            in_ready_q  <= (count_d != CNT_W'(DEPTH));
            out_valid_q <= (count_d != '0);
            err_valid_q <= accept_s && (err_code_s != 2'b00);
            if (accept_s && (err_code_s != 2'b00)) begin
                err_code_q <= err_code_s;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q[rd_ptr_q];
    assign out_addr  = tag_q[rd_ptr_q];
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;

endmodule
